// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through output,
// occupancy count, static almost-full/almost-empty thresholds and error pulses.
module sync_fifo_prog #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full_c, empty_c, wr_acc_c, rd_acc_c;

  // Status comes only from the registered count, so accepts never see same-cycle traffic.
  always_comb begin
    full_c   = (count_q == CNT_MAX);
    empty_c  = (count_q == '0);
    wr_acc_c = wr_en && !full_c;
    rd_acc_c = rd_en && !empty_c;
  end

  // Pointers wrap explicitly at DEPTH-1 so any depth works.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en && full_c;
    underflow_d = rd_en && empty_c;

    if (wr_acc_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_acc_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = mem_q[rd_ptr_q];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc_c) begin
        dout_d = mem_q[rd_ptr_q];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign data_out = dout_q;
  end

  assign full         = full_c;
  assign empty        = empty_c;
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO with arbitrary (non-power-of-two) depth, selectable standard or first-word-fall-through (FWFT) read mode, an occupancy count, static almost-full/almost-empty thresholds and overflow/underflow error pulses. It is the same-clock-domain buffer for datapaths that do not need clock-domain crossing. It replaces ad-hoc power-of-two FIFOs that offer only full/empty status.

## Interface
Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries. Any integer ≥ 2; a power of two is not required.
- FWFT, 0: read mode. 0 = standard (registered read); 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH. Legal range 0..DEPTH-1.

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous and active-low.
- wr_en  in  1  write request.
- data_in  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_THRESH.
- rd_en  in  1  read (pop) request.
- data_out  out  WIDTH  read data.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  CW  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse when a write is rejected.
- underflow  out  1  one-cycle pulse when a read is rejected.

## Operation
- Storage: DEPTH×WIDTH array, not reset. The binary wr_ptr and rd_ptr each range 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. There is no extra-MSB trick.
- Occupancy is tracked in a separate count register.
- Accepted write: wr_en && !full. Stores data_in at mem[wr_ptr] and advances wr_ptr.
- Accepted read: rd_en && !empty. Advances rd_ptr.
- full and empty are evaluated from the registered count at the start of the cycle. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- Count update: +1 for a write only, −1 for a read only, unchanged for both or neither.
- full, empty, almost_full and almost_empty are combinational functions of the registered count only. They have no combinational path from wr_en or rd_en.
- overflow is registered: it is 1 in the cycle after wr_en && full.
- underflow is registered: it is 1 in the cycle after rd_en && empty.
- FWFT=0: on an accepted read, data_out is loaded with mem[rd_ptr] at the clock edge. Otherwise data_out holds its value.
- FWFT=1: data_out = mem[rd_ptr] combinationally. It is valid whenever empty=0 and rd_en pops the shown word. data_out is not checked while empty=1.
- Reset (asynchronous assert, removal synchronous to clk):
  - wr_ptr, rd_ptr and count go to 0.
  - empty=1, almost_empty=1 (AE_THRESH ≥ 0), full=0.
  - almost_full=0, overflow=0, underflow=0.
  - data_out=0 when FWFT=0.
  - Any in-flight write or read is dropped. Memory contents are stale and unreachable.

## Timing
- Write to empty visible: a word accepted at edge N gives empty=0 and count=1 after edge N.
  - FWFT=1: the word is on data_out after edge N.
  - FWFT=0: rd_en in cycle N+1 puts the word on data_out after edge N+1.
- Read latency: FWFT=0 is 1 cycle from rd_en to data_out; FWFT=1 is 0 cycles (data is already presented).
- Flags update on the same edge as count. There is no extra synchronizer latency.
- Pointer wrap: the slot written at wr_ptr = DEPTH-1 is followed by slot 0. Order is preserved across wrap for any DEPTH.

## Test plan
- Reset mid-operation: DEPTH=5, WIDTH=8, write 3 words, assert rst for 1 cycle → count=0, empty=1, almost_empty=1, full=0, data_out=0 (FWFT=0). The next write/read returns the new data only.
- Fill/drain with non-power-of-two depth: DEPTH=5, write 0x11..0x15 → full=1, count=5. A 6th write → overflow pulses 1 cycle, count stays 5. Read all 5 → 0x11..0x15 in order, empty=1. A further read → underflow pulse.
- Wrap-around: DEPTH=5, interleave writes and reads for 12 words (0x00..0x0B) with occupancy ≤ 3 → output sequence exactly 0x00..0x0B, no flag errors.
- Simultaneous access:
  - At count=2, assert wr_en and rd_en together → count stays 2 and data stays in order.
  - At full, assert both → the read is accepted, the write is rejected, overflow=1, count=4.
  - At empty, assert both → the write is accepted, underflow=1, count=1.
- Thresholds: DEPTH=8, AF_THRESH=6, AE_THRESH=2:
  - almost_empty is 1 for count 0..2 and 0 at 3.
  - almost_full is 0 at 5 and 1 for count 6..8.
  - Both flags hold the same values while draining.
- FWFT=1: write 0xA5 to an empty FIFO → data_out=0xA5 on the next cycle with no rd_en. rd_en pops it → empty=1. Write 0x01 then 0x02 → data_out=0x01, then 0x02 after one pop.
